lcd_timing: RTL

LCD_TIMING -- requirements
Module: lcd_timing

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_delay.sv | 45 ++++
 rtl/lcd_timing.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared timing defaults for the LCD timing generator.
// Holds the default 800x480 panel timing, the derived line/frame totals,
// the sync/de bundle type carried down the delay pipeline and its idle value.
package lcd_pkg;

    localparam int DEF_H_ACTIVE      = 800;
    localparam int DEF_H_FRONT       = 40;
    localparam int DEF_H_SYNC        = 48;
    localparam int DEF_H_BACK        = 40;
    localparam int DEF_V_ACTIVE      = 480;
    localparam int DEF_V_FRONT       = 13;
    localparam int DEF_V_SYNC        = 3;
    localparam int DEF_V_BACK        = 29;
    localparam int DEF_PIXEL_LATENCY = 1;

    // Counters are 10 bits wide, so every total must fit below 1024.
    localparam int CNT_W = 10;

    // Length of a line or frame as the sum of its four regions.
    function automatic logic [CNT_W-1:0] span_total(input int active, input int front,
                                                    input int sync, input int back);
        return CNT_W'(active + front + sync + back);
    endfunction

    localparam logic [CNT_W-1:0] DEF_H_TOTAL =
        span_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam logic [CNT_W-1:0] DEF_V_TOTAL =
        span_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    // Panel control bundle; syncs are active-low, de active-high.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

endpackage

// File: rtl/lcd_delay.sv
// Resettable shift-register delay line.
// Ports: clock/reset_n (async active-low, stages load IDLE),
//        data_in  -> value entering the first stage,
//        data_out -> value after DEPTH clocks,
//        last_in  -> value about to be loaded into the final stage
//                    (i.e. what data_out becomes on the next edge).
module lcd_delay #(
    parameter int               WIDTH = 3,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] IDLE  = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] last_in
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift chain, all stages returning to IDLE on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= IDLE;
            end
        end else begin
            stage_r[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign data_out = stage_r[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_single
            assign last_in = data_in;
        end else begin : g_multi
            assign last_in = stage_r[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/lcd_timing.sv
// LCD panel timing generator.
// Ports: clock, reset_n (async active-low);
//        x, y          -> pixel coordinate to the pattern generator (0 outside active area);
//        red/green/blue <- pattern data, PIXEL_LATENCY clocks behind x/y;
//        lcd_r/g/b     -> panel pixel data, zero whenever lcd_de is low;
//        lcd_hs, lcd_vs -> active-low syncs; lcd_de -> active-high data enable;
//        frame_start   -> one-clock pulse alongside x=0,y=0 of each frame.
module lcd_timing
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int H_FRONT       = DEF_H_FRONT,
    parameter int H_SYNC        = DEF_H_SYNC,
    parameter int H_BACK        = DEF_H_BACK,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int V_FRONT       = DEF_V_FRONT,
    parameter int V_SYNC        = DEF_V_SYNC,
    parameter int V_BACK        = DEF_V_BACK,
    parameter int PIXEL_LATENCY = DEF_PIXEL_LATENCY
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [9:0] x,
    output logic [9:0] y,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [7:0] lcd_r,
    output logic [7:0] lcd_g,
    output logic [7:0] lcd_b,
    output logic       lcd_hs,
    output logic       lcd_vs,
    output logic       lcd_de,
    output logic       frame_start
);

    localparam logic [9:0] H_TOTAL  = span_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam logic [9:0] V_TOTAL  = span_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0] h_count_r;
    logic [9:0] v_count_r;
    logic       h_last_s;
    logic       v_last_s;
    logic       de_s;
    logic       hs_s;
    logic       vs_s;
    logic       frame_first_s;

    logic [9:0] x_r;
    logic [9:0] y_r;
    logic       frame_start_r;
    sync_t      sync_r;
    sync_t      sync_out_s;
    sync_t      sync_pre_s;
    logic [7:0] lcd_r_r;
    logic [7:0] lcd_g_r;
    logic [7:0] lcd_b_r;

    // Wrap detection and region decode of the current counter state.
    always_comb begin
        h_last_s      = (h_count_r == H_TOTAL - 10'd1);
        v_last_s      = (v_count_r == V_TOTAL - 10'd1);
        de_s          = (h_count_r < H_ACT) && (v_count_r < V_ACT);
        hs_s          = !((h_count_r >= HS_START) && (h_count_r < HS_END));
        vs_s          = !((v_count_r >= VS_START) && (v_count_r < VS_END));
        frame_first_s = (h_count_r == 10'd0) && (v_count_r == 10'd0);
    end

    // Horizontal and vertical position counters; v steps on every h wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_count_r <= 10'd0;
            v_count_r <= 10'd0;
        end else if (h_last_s) begin
            h_count_r <= 10'd0;
            v_count_r <= v_last_s ? 10'd0 : v_count_r + 10'd1;
        end else begin
            h_count_r <= h_count_r + 10'd1;
        end
    end

    // Registered coordinates, frame pulse and undelayed sync/de.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_r           <= 10'd0;
            y_r           <= 10'd0;
            frame_start_r <= 1'b0;
            sync_r        <= SYNC_IDLE;
        end else begin
            x_r           <= de_s ? h_count_r : 10'd0;
            y_r           <= de_s ? v_count_r : 10'd0;
            frame_start_r <= de_s && frame_first_s;
            sync_r        <= '{hs: hs_s, vs: vs_s, de: de_s};
        end
    end

    // One extra stage beyond the pattern latency covers the pixel data register.
    lcd_delay #(
        .WIDTH (3),
        .DEPTH (PIXEL_LATENCY + 1),
        .IDLE  (SYNC_IDLE)
    ) u_sync_delay (
        .clock    (clock),
        .reset_n  (reset_n),
        .data_in  (sync_r),
        .data_out (sync_out_s),
        .last_in  (sync_pre_s)
    );

    // Pixel data register, blanked by the de value that lcd_de takes on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lcd_r_r <= 8'd0;
            lcd_g_r <= 8'd0;
            lcd_b_r <= 8'd0;
        end else if (sync_pre_s.de) begin
            lcd_r_r <= red;
            lcd_g_r <= green;
            lcd_b_r <= blue;
        end else begin
            lcd_r_r <= 8'd0;
            lcd_g_r <= 8'd0;
            lcd_b_r <= 8'd0;
        end
    end

    assign x           = x_r;
    assign y           = y_r;
    assign frame_start = frame_start_r;
    assign lcd_hs      = sync_out_s.hs;
    assign lcd_vs      = sync_out_s.vs;
    assign lcd_de      = sync_out_s.de;
    assign lcd_r       = lcd_r_r;
    assign lcd_g       = lcd_g_r;
    assign lcd_b       = lcd_b_r;

endmodule
